// File: rtl/bch_common.sv
// Constants shared across the BCH decoder datapath: shift-direction codes
// and the Galois field width.
package bch_common;

  localparam int FWD    = 0;
  localparam int REV    = -1;
  localparam int GF_LEN = 10;

endpackage

// File: rtl/seq_to_sim_register_ps_last_shift_stage.sv
// One slot of the shift chain: enabled word register with asynchronous
// reset and a synchronous clear that takes priority over the load.
module seq_to_sim_register_ps_last_shift_stage #(
  parameter int W = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/seq_to_sim_register_ps_last.sv
// Sequential-to-simultaneous converter: gathers words into a shift chain and
// publishes the whole frame, last word included, when the last word arrives.
module seq_to_sim_register_ps_last
  import bch_common::*;
#(
  parameter string OUTTER_MODULE = "",
  parameter string MODULE_NAME   = "sequentialToSimultaneousRegister_psLast",
  parameter int    DIRECTION     = 0,
  parameter int    SHIFT_LEN     = 8,
  parameter int    BIT_WIDTH     = 40
) (
  input  logic                           clk,
  input  logic                           in_ctr_Srst,
  input  logic                           in_ctr_en,
  input  logic                           in_ctr_last,
  input  logic [BIT_WIDTH-1:0]           in,
  output logic [SHIFT_LEN*BIT_WIDTH-1:0] out
);

  localparam bit REVERSE = (DIRECTION == REV);

  logic                                capture;
  logic                                advance;
  logic [SHIFT_LEN-1:0][BIT_WIDTH-1:0] sh;
  logic [SHIFT_LEN-1:0][BIT_WIDTH-1:0] nxt;

  assign capture = in_ctr_en & in_ctr_last;
  assign advance = in_ctr_en & ~in_ctr_last;

  // A capture clears the chain so the following frame starts from all-zero slots.
  for (genvar k = 0; k < SHIFT_LEN; k++) begin : g_slot
    if (SHIFT_LEN == 1) begin : g_single
      assign nxt[k] = in;
    end else if (!REVERSE) begin : g_fwd
      if (k == 0) begin : g_head
        assign nxt[k] = in;
      end else begin : g_body
        assign nxt[k] = sh[k-1];
      end
    end else begin : g_rev
      if (k == SHIFT_LEN - 1) begin : g_head
        assign nxt[k] = in;
      end else begin : g_body
        assign nxt[k] = sh[k+1];
      end
    end

    seq_to_sim_register_ps_last_shift_stage #(
      .W(BIT_WIDTH)
    ) u_stage (
      .clk(clk),
      .rst(in_ctr_Srst),
      .clr(capture),
      .en (advance),
      .d  (nxt[k]),
      .q  (sh[k])
    );
  end

  always_ff @(posedge clk or posedge in_ctr_Srst) begin
    if (in_ctr_Srst) begin
      out <= '0;
    end else if (capture) begin
      out <= nxt;
    end else begin
      out <= out;
    end
  end

  initial begin
    $display("%s.%s: DIRECTION=%0d SHIFT_LEN=%0d BIT_WIDTH=%0d",
             OUTTER_MODULE, MODULE_NAME, DIRECTION, SHIFT_LEN, BIT_WIDTH);
    if (SHIFT_LEN < 1 || BIT_WIDTH < 1) begin
      $display("ERROR: %s.%s: SHIFT_LEN and BIT_WIDTH must both be >= 1",
               OUTTER_MODULE, MODULE_NAME);
    end
  end

endmodule

// File: tb/tb_seq_to_sim_register_ps_last.sv
// Directed bench: forward/reverse 2-bit instances and a forward 40-bit
// instance share one stimulus stream and are checked against hand values.
module tb_seq_to_sim_register_ps_last;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         last;
  logic [39:0]  in_w;
  logic [15:0]  out_f2;
  logic [15:0]  out_r2;
  logic [319:0] out_f40;
  logic [319:0] exp_w;
  int           n_checks = 0;
  int           n_pass   = 0;

  always #5 clk = ~clk;

  seq_to_sim_register_ps_last #(
    .OUTTER_MODULE("tb"), .MODULE_NAME("dut_f2"),
    .DIRECTION(0), .SHIFT_LEN(8), .BIT_WIDTH(2)
  ) dut_f2 (
    .clk(clk), .in_ctr_Srst(rst), .in_ctr_en(en), .in_ctr_last(last),
    .in(in_w[1:0]), .out(out_f2)
  );

  seq_to_sim_register_ps_last #(
    .OUTTER_MODULE("tb"), .MODULE_NAME("dut_r2"),
    .DIRECTION(-1), .SHIFT_LEN(8), .BIT_WIDTH(2)
  ) dut_r2 (
    .clk(clk), .in_ctr_Srst(rst), .in_ctr_en(en), .in_ctr_last(last),
    .in(in_w[1:0]), .out(out_r2)
  );

  seq_to_sim_register_ps_last #(
    .OUTTER_MODULE("tb"), .MODULE_NAME("dut_f40"),
    .DIRECTION(0), .SHIFT_LEN(8), .BIT_WIDTH(40)
  ) dut_f40 (
    .clk(clk), .in_ctr_Srst(rst), .in_ctr_en(en), .in_ctr_last(last),
    .in(in_w), .out(out_f40)
  );

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then settle just after the rising edge.
  task automatic push(input logic [39:0] w, input logic e, input logic l);
    in_w = w;
    en   = e;
    last = l;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; last = 1'b0; in_w = 40'h0;
    push(40'h0, 1'b1, 1'b1);
    push(40'h3, 1'b1, 1'b1);
    check("reset_f2",  320'(out_f2),  320'h0);
    check("reset_r2",  320'(out_r2),  320'h0);
    check("reset_f40", out_f40,       320'h0);
    rst = 1'b0;

    // Full frame 0,1,2,3,0,1,2,3, last on the eighth word.
    for (int i = 0; i < 7; i++) push(40'(i % 4), 1'b1, 1'b0);
    check("accum_hold_f2", 320'(out_f2), 320'h0);
    push(40'h3, 1'b1, 1'b1);
    check("full_fwd", 320'(out_f2), 320'h1B1B);
    check("full_rev", 320'(out_r2), 320'hE4E4);
    check("full_f40_slot0", 320'(out_f40[39:0]),    320'h3);
    check("full_f40_slot5", 320'(out_f40[239:200]), 320'h2);
    for (int i = 0; i < 5; i++) push(40'h2, 1'b0, 1'(i == 2));
    check("idle_hold_fwd", 320'(out_f2), 320'h1B1B);
    check("idle_hold_rev", 320'(out_r2), 320'hE4E4);

    // Short frame with an enable gap and an unqualified last pulse.
    push(40'hAAAAAAAAAA, 1'b1, 1'b0);
    push(40'hFFFFFFFFFF, 1'b0, 1'b1);
    check("ignored_last", 320'(out_f2), 320'h1B1B);
    push(40'h5555555555, 1'b1, 1'b1);
    check("short_f40", out_f40, {240'h0, 40'hAAAAAAAAAA, 40'h5555555555});
    check("short_fwd", 320'(out_f2), 320'h0009);
    check("short_rev", 320'(out_r2), 320'h6000);

    // Overflow: ten words, only the last eight survive.
    for (int i = 1; i <= 10; i++) push(40'(i), 1'b1, 1'(i == 10));
    exp_w = '0;
    for (int k = 0; k < 8; k++) exp_w[k*40 +: 40] = 40'(10 - k);
    check("overflow_f40", out_f40, exp_w);
    push(40'h7, 1'b1, 1'b1);
    check("b2b_f40", out_f40, 320'h7);
    check("b2b_fwd", 320'(out_f2), 320'h0003);
    check("b2b_rev", 320'(out_r2), 320'hC000);

    // Mid-frame asynchronous reset, then a short fresh frame.
    for (int i = 0; i < 4; i++) push(40'(8'h11 + i), 1'b1, 1'b0);
    #2;
    rst = 1'b1; en = 1'b1; last = 1'b1;
    #1;
    check("async_rst_f40", out_f40, 320'h0);
    check("async_rst_f2",  320'(out_f2), 320'h0);
    @(posedge clk);
    #1;
    check("rst_held_f40", out_f40, 320'h0);
    rst = 1'b0;
    push(40'h21, 1'b1, 1'b0);
    push(40'h22, 1'b1, 1'b0);
    push(40'h23, 1'b1, 1'b1);
    check("post_rst_f40", out_f40, {200'h0, 40'h21, 40'h22, 40'h23});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
